// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor.
// Holds the FSM state encoding so that status-register decode logic elsewhere can
// interpret the 2-bit 'state' output, plus small helpers for sizing the cycle counter.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        StPllRst   = 2'd0,
        StWaitLock = 2'd1,
        StStable   = 2'd2,
        StRun      = 2'd3
    } pll_sup_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width needed to count 0 .. max_cycles-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles) : 1;
    endfunction

endpackage

// File: rtl/sync_1bit.sv
// Two-flop synchroniser for a single asynchronous level input.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, clears both flops
//   d_i - asynchronous input
//   q_o - synchronised output, two cycles of latency
module sync_1bit (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, waits for lock with timeout/retry, requires
// a stable lock window before releasing the system reset, and tracks lock loss.
// Ports:
//   clk          - free-running reference clock (not the PLL output)
//   rst          - synchronous active-high block reset
//   pll_locked   - raw PLL lock indication, asynchronous
//   force_relock - pulse, restarts the PLL reset sequence from any state
//   clr_status   - pulse, clears lock_lost and retry_cnt
//   pll_rst      - high while the PLL is held in reset
//   sys_rst      - active-high system reset, low only in RUN
//   state        - current FSM state (see pll_sup_pkg)
//   retry_cnt    - saturating count of lock timeouts
//   lock_lost    - sticky, set when lock drops while running
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned RETRY_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               force_relock,
    input  logic               clr_status,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic [1:0]         state,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               lock_lost
);

    localparam int unsigned CntW = cnt_width(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam logic [CntW-1:0]    RstLast    = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0]    LockLast   = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0]    StableLast = CntW'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RetryMax   = '1;

    pll_sup_state_e     state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lock_lost_q, lock_lost_d;
    logic               locked_s;
    logic               retry_inc;
    logic               lost_set;

    sync_1bit u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (locked_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StPllRst;
            cnt_q       <= '0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        retry_inc = 1'b0;
        lost_set  = 1'b0;

        if (force_relock) begin
            // Overrides any coinciding timeout, so no retry is counted.
            state_d = StPllRst;
        end else begin
            unique case (state_q)
                StPllRst: begin
                    if (cnt_q == RstLast) state_d = StWaitLock;
                end
                StWaitLock: begin
                    if (locked_s) begin
                        state_d = StStable;
                    end else if (cnt_q == LockLast) begin
                        state_d   = StPllRst;
                        retry_inc = 1'b1;
                    end
                end
                StStable: begin
                    if (!locked_s) begin
                        state_d = StWaitLock;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    cnt_d = cnt_q;
                    if (!locked_s) begin
                        state_d  = StPllRst;
                        lost_set = 1'b1;
                    end
                end
            endcase
        end

        // Counter restarts on every state change, and on a forced restart of PLL_RST.
        if (force_relock || (state_d != state_q)) cnt_d = '0;

        // Set/increment win over a coinciding clear.
        retry_d = retry_q;
        if (retry_inc) begin
            retry_d = (retry_q == RetryMax) ? retry_q : retry_q + RETRY_W'(1);
        end else if (clr_status) begin
            retry_d = '0;
        end

        lock_lost_d = lock_lost_q;
        if (lost_set) begin
            lock_lost_d = 1'b1;
        end else if (clr_status) begin
            lock_lost_d = 1'b0;
        end
    end

    // Moore outputs, decoded from registered state only
    always_comb begin
        pll_rst   = (state_q == StPllRst);
        sys_rst   = (state_q != StRun);
        state     = state_q;
        retry_cnt = retry_q;
        lock_lost = lock_lost_q;
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed lock/timeout/glitch/relock
// scenarios with fixed expectations, then randomized stimulus, all cycles compared
// against a behavioural model of the supervisor's rules.
module tb_pll_lock_supervisor;

    localparam int unsigned PRst = 4;
    localparam int unsigned Tmo  = 32;
    localparam int unsigned Stb  = 8;
    localparam int unsigned RW   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          force_relock = 1'b0;
    logic          clr_status = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic [1:0]    state;
    logic [RW-1:0] retry_cnt;
    logic          lock_lost;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: phase 0..3, cycles spent in the phase, lock sample history.
    int m_state = 0;
    int m_time  = 0;
    int m_retry = 0;
    bit m_lost  = 1'b0;
    bit m_hist [2];

    always #20 clk = ~clk;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (PRst),
        .LOCK_TIMEOUT   (Tmo),
        .STABLE_CYCLES  (Stb),
        .RETRY_W        (RW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .clr_status   (clr_status),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .state        (state),
        .retry_cnt    (retry_cnt),
        .lock_lost    (lock_lost)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit ls;
        int nxt;
        bit inc;
        bit setl;
        ls = m_hist[1];
        if (rst) begin
            m_state = 0; m_time = 0; m_retry = 0; m_lost = 1'b0;
            m_hist[0] = 1'b0; m_hist[1] = 1'b0;
            return;
        end
        m_hist[1] = m_hist[0];
        m_hist[0] = pll_locked;
        nxt = m_state; inc = 1'b0; setl = 1'b0;
        if (force_relock) begin
            nxt = 0;
        end else begin
            case (m_state)
                0: if (m_time + 1 == PRst) nxt = 1;
                1: begin
                    if (ls) nxt = 2;
                    else if (m_time + 1 == Tmo) begin nxt = 0; inc = 1'b1; end
                end
                2: begin
                    if (!ls) nxt = 1;
                    else if (m_time + 1 == Stb) nxt = 3;
                end
                default: if (!ls) begin nxt = 0; setl = 1'b1; end
            endcase
        end
        m_time  = (force_relock || nxt != m_state) ? 0 : m_time + 1;
        m_state = nxt;
        if (inc) m_retry = (m_retry < 3) ? m_retry + 1 : 3;
        else if (clr_status) m_retry = 0;
        if (setl) m_lost = 1'b1;
        else if (clr_status) m_lost = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("pll_rst", 32'(pll_rst), 32'(m_state == 0));
        check("sys_rst", 32'(sys_rst), 32'(m_state != 3));
        check("state", 32'(state), 32'(m_state));
        check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
        check("lock_lost", 32'(lock_lost), 32'(m_lost));
    endtask

    // Run until pll_rst makes the requested transition; n = cycles taken (100 = gave up).
    task automatic wait_pll_rst_edge(input bit rising, output int n);
        bit prev;
        bit hit;
        prev = pll_rst; n = 0; hit = 1'b0;
        while (!hit && n < 100) begin
            cycle();
            n++;
            hit  = (pll_rst == rising) && (prev != rising);
            prev = pll_rst;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pll_rst"}, 32'(pll_rst), 1);
        check({tag, "_sys_rst"}, 32'(sys_rst), 1);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_retry"}, 32'(retry_cnt), 0);
        check({tag, "_lost"}, 32'(lock_lost), 0);
    endtask

    initial begin
        int n;
        bit saw;

        // Reset state
        repeat (3) cycle();
        check_reset_outputs("reset");

        // Release: PLL reset hold, then lock 2 cycles after pll_rst falls
        rst = 1'b0;
        n = 1;
        cycle();
        while (pll_rst && n < 20) begin n++; cycle(); end
        check("pll_rst_hold", n, PRst);
        repeat (2) cycle();
        pll_locked = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (sys_rst && n < 60);
        check("lock_to_run_edges", n, 11);
        check("run_state", 32'(state), 3);

        // Glitch in STABLE at stable count 5
        force_relock = 1'b1; cycle(); force_relock = 1'b0;
        n = 0;
        while (state != 2'd2 && n < 40) begin cycle(); n++; end
        check("reach_stable", 32'(state), 2);
        repeat (5) cycle();
        pll_locked = 1'b0; cycle(); pll_locked = 1'b1;
        n = 0; saw = 1'b0;
        do begin cycle(); n++; if (state == 2'd1) saw = 1'b1; end while (sys_rst && n < 60);
        check("glitch_back_to_wait", saw, 1);
        check("relock_to_run_edges", n, 11);
        check("retry_after_glitch", 32'(retry_cnt), 0);

        // Lock loss in RUN, then held low: timeouts with saturating retry
        pll_locked = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (!sys_rst && n < 20);
        check("drop_to_reset_edges", n, 3);
        check("drop_pll_rst", 32'(pll_rst), 1);
        check("drop_lock_lost", 32'(lock_lost), 1);
        for (int k = 1; k <= 4; k++) begin
            wait_pll_rst_edge(1'b1, n);
            check("repulse_period", n, PRst + Tmo);
            check("retry_seq", 32'(retry_cnt), (k < 3) ? k : 3);
        end
        clr_status = 1'b1; cycle(); clr_status = 1'b0;
        check("clr_lock_lost", 32'(lock_lost), 0);
        check("clr_retry", 32'(retry_cnt), 0);

        // force_relock exactly on the WAIT_LOCK timeout edge
        wait_pll_rst_edge(1'b0, n);
        check("enter_wait_a", 32'(state), 1);
        repeat (Tmo) cycle();
        check("timeout_retry_one", 32'(retry_cnt), 1);
        wait_pll_rst_edge(1'b0, n);
        check("enter_wait_b", 32'(state), 1);
        repeat (Tmo - 1) cycle();
        force_relock = 1'b1; cycle(); force_relock = 1'b0;
        check("force_state", 32'(state), 0);
        check("force_no_retry", 32'(retry_cnt), 1);
        n = 1;
        cycle();
        while (pll_rst && n < 20) begin n++; cycle(); end
        check("force_hold", n, PRst);

        // Reset asserted from RUN
        pll_locked = 1'b1;
        n = 0;
        while (sys_rst && n < 80) begin cycle(); n++; end
        check("run_before_rst", 32'(state), 3);
        rst = 1'b1; cycle();
        check_reset_outputs("rst_in_run");
        rst = 1'b0;

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) pll_locked = ~pll_locked;
            force_relock = ($urandom_range(0, 199) == 0);
            clr_status   = ($urandom_range(0, 99) == 0);
            rst          = ($urandom_range(0, 499) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
